snake_body_sched: RTL

SNAKE_BODY_SCHED -- requirements
Module: snake_body_sched

---
 rtl/snake_body_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/snake_body_sched.sv
// Snake body ring scheduler: segment ring with push/pop game steps and a
// renderer scan port. Optional dropped-tick counter under SNAKE_TICK_MISS_EN.
module snake_body_sched #(
  parameter int         MAX_LEN  = 64,
  parameter int         INIT_LEN = 3,
  parameter logic [2:0] INIT_DIR = 3'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       grow,
  input  logic [2:0]                 dir_in,
  input  logic                       scan_req,
  input  logic [$clog2(MAX_LEN)-1:0] scan_idx,
  output logic                       scan_ack,
  output logic [2:0]                 scan_data,
  output logic                       scan_valid,
  output logic [$clog2(MAX_LEN):0]   len,
  output logic                       busy,
  output logic                       step_done,
  output logic                       ovf,
  output logic [7:0]                 miss_cnt
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PUSH,
    S_POP,
    S_SCAN
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] head, tail, init_cnt;
  logic [LW-1:0] len_r;
  logic          ovf_r;
  logic          full;
  logic          grow_l;
  logic [2:0]    dir_l;
  logic [AW-1:0] scan_addr;
  logic          scan_oob;
  logic [2:0]    ring [MAX_LEN];

  assign full = (len_r == LW'(MAX_LEN));
  assign busy = (state != S_IDLE);
  assign len  = len_r;
  assign ovf  = ovf_r;

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (init_cnt == AW'(INIT_LEN - 1)) state_nxt = S_IDLE;
      S_IDLE: begin
        if (tick)          state_nxt = S_PUSH;
        else if (scan_req) state_nxt = S_SCAN;
      end
      S_PUSH: state_nxt = (grow_l && !full) ? S_IDLE : S_POP;
      S_POP:  state_nxt = S_IDLE;
      S_SCAN: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      head       <= AW'(INIT_LEN);
      tail       <= '0;
      len_r      <= LW'(INIT_LEN);
      ovf_r      <= 1'b0;
      init_cnt   <= '0;
      scan_ack   <= 1'b0;
      scan_valid <= 1'b0;
      step_done  <= 1'b0;
      scan_data  <= 3'd0;
    end else begin
      state      <= state_nxt;
      scan_ack   <= 1'b0;
      scan_valid <= 1'b0;
      step_done  <= 1'b0;
      case (state)
        S_INIT: init_cnt <= init_cnt + AW'(1);
        S_IDLE: if (!tick && scan_req) scan_ack <= 1'b1;
        S_PUSH: begin
          head <= head + AW'(1);
          if (grow_l && !full) begin
            len_r     <= len_r + LW'(1);
            step_done <= 1'b1;
          end else if (grow_l) begin
            ovf_r <= 1'b1;
          end
        end
        S_POP: begin
          tail      <= tail + AW'(1);
          step_done <= 1'b1;
        end
        S_SCAN: begin
          scan_valid <= 1'b1;
          scan_data  <= scan_oob ? 3'd0 : ring[scan_addr];
        end
        default: ;
      endcase
    end
  end

  // Step/scan operands captured in IDLE so the requester may change inputs afterwards
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (tick) begin
        grow_l <= grow;
        dir_l  <= dir_in;
      end else if (scan_req) begin
        scan_addr <= head - AW'(1) - scan_idx;
        scan_oob  <= ({1'b0, scan_idx} >= len_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT)      ring[init_cnt] <= INIT_DIR;
      else if (state == S_PUSH) ring[head]     <= dir_l;
    end
  end

`ifdef SNAKE_TICK_MISS_EN
  logic [7:0] miss_r;

  always_ff @(posedge clk) begin
    if (reset)                                  miss_r <= 8'd0;
    else if (tick && busy && miss_r != 8'hFF)   miss_r <= miss_r + 8'd1;
  end

  assign miss_cnt = miss_r;
`else
  assign miss_cnt = 8'd0;
`endif

endmodule
